ir_control_bank: RTL and testbench

- Parametrised IR-remote command decoder for the synthesizer.
- Converts 8-bit IR key codes from the IR receiver into persistent control state: tone select, autoplay, N channel enables, mute, and a saturating volume level.
- Acts only on a per-frame valid strobe. A repeat-holdoff timer prevents held keys from re-toggling, while volume keys auto-repeat.
- Sits between the IR receiver and the tone generator / mixer.

---
 rtl/ir_control_bank.sv | 183 ++++++++++++++++++
 tb/tb_ir_control_bank.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ir_control_bank.sv
// rtl/ir_control_bank.sv - IR key-code decoder driving persistent synth control state
//
// Purpose: turns per-frame IR key codes into tone/autoplay/channel/mute/volume
// state, with a repeat-holdoff window so held keys do not re-toggle while
// volume keys auto-repeat.
//
// Ports:
//   clk          system clock
//   iRST         asynchronous active-high reset
//   code         IR key code, qualified by code_valid
//   code_valid   one-cycle strobe per decoded IR frame
//   tone_switch  tone select
//   autoplay     autoplay enable
//   channel_en   per-channel enables [NUM_CH-1:0]
//   mute         mixer mute
//   volume       saturating volume level [VOL_W-1:0]
//   cmd_ack      one-cycle pulse when a command changes or re-applies state
//   cmd_drop     one-cycle pulse when a strobe or code is ignored
module ir_control_bank #(
  parameter int          NUM_CH         = 4,
  parameter int          VOL_W          = 4,
  parameter int          VOL_RESET      = 8,
  parameter int          HOLDOFF_CYCLES = 5000000,
  parameter logic [7:0]  CH_OFF_BASE    = 8'h10,
  parameter logic [7:0]  CH_ON_BASE     = 8'h20,
  parameter logic [7:0]  CH_TOG_BASE    = 8'h30
) (
  input  logic              clk,
  input  logic              iRST,
  input  logic [7:0]        code,
  input  logic              code_valid,
  output logic              tone_switch,
  output logic              autoplay,
  output logic [NUM_CH-1:0] channel_en,
  output logic              mute,
  output logic [VOL_W-1:0]  volume,
  output logic              cmd_ack,
  output logic              cmd_drop
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [VOL_W-1:0] VOL_MAX   = '1;
  localparam logic [VOL_W-1:0] VOL_INIT  = VOL_W'(VOL_RESET);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [7:0] C_TONE0 = 8'h01;
  localparam logic [7:0] C_TONE1 = 8'h02;
  localparam logic [7:0] C_AUTO0 = 8'h03;
  localparam logic [7:0] C_AUTO1 = 8'h04;
  localparam logic [7:0] C_MUTE  = 8'h05;
  localparam logic [7:0] C_VOLUP = 8'h06;
  localparam logic [7:0] C_VOLDN = 8'h07;

  logic [1:0]       state, state_nxt;
  logic [7:0]       cmd_reg, last_code;
  logic [CNT_W-1:0] hold_cnt;
  logic             drop_pend;

  // Next values of the control outputs, computed from cmd_reg in EXEC
  logic              tone_nxt, auto_nxt, mute_nxt, ack_nxt, drop_nxt;
  logic [NUM_CH-1:0] ch_nxt;
  logic [VOL_W-1:0]  vol_nxt;
  logic              known;

  // A strobe in HOLD is taken if it is a new key, or a volume key repeating
  logic accept_hold;
  logic strobe_take, strobe_drop;

  assign accept_hold = (code != last_code) || (code == C_VOLUP) || (code == C_VOLDN);
  assign strobe_take = code_valid && ((state == IDLE) || ((state == HOLD) && accept_hold));
  assign strobe_drop = code_valid && ((state == EXEC) || ((state == HOLD) && !accept_hold));

  // State register
  always_ff @(posedge clk or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (code_valid) state_nxt = EXEC;
      EXEC: state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
      HOLD: begin
        if (strobe_take)                      state_nxt = EXEC;
        else if (code_valid)                  state_nxt = HOLD;
        else if (hold_cnt <= CNT_W'(1))       state_nxt = IDLE;
        else                                  state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: decode cmd_reg into next control values
  always_comb begin
    tone_nxt = tone_switch;
    auto_nxt = autoplay;
    mute_nxt = mute;
    ch_nxt   = channel_en;
    vol_nxt  = volume;
    known    = 1'b0;
    ack_nxt  = 1'b0;
    drop_nxt = drop_pend;
    if (state == EXEC) begin
      case (cmd_reg)
        C_TONE0: begin tone_nxt = 1'b0;  known = 1'b1; end
        C_TONE1: begin tone_nxt = 1'b1;  known = 1'b1; end
        C_AUTO0: begin auto_nxt = 1'b0;  known = 1'b1; end
        C_AUTO1: begin auto_nxt = 1'b1;  known = 1'b1; end
        C_MUTE:  begin mute_nxt = ~mute; known = 1'b1; end
        C_VOLUP: begin
          known    = 1'b1;
          mute_nxt = 1'b0;
          if (volume != VOL_MAX) vol_nxt = volume + VOL_W'(1);
        end
        C_VOLDN: begin
          known    = 1'b1;
          mute_nxt = 1'b0;
          if (volume != '0) vol_nxt = volume - VOL_W'(1);
        end
        default: begin
          // Channel codes; only indices below NUM_CH match
          for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_reg == CH_OFF_BASE + 8'(i)) begin ch_nxt[i] = 1'b0;           known = 1'b1; end
            if (cmd_reg == CH_ON_BASE  + 8'(i)) begin ch_nxt[i] = 1'b1;           known = 1'b1; end
            if (cmd_reg == CH_TOG_BASE + 8'(i)) begin ch_nxt[i] = ~channel_en[i]; known = 1'b1; end
          end
        end
      endcase
      ack_nxt  = known;
      drop_nxt = drop_pend | ~known;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge iRST) begin
    if (iRST) begin
      cmd_reg     <= 8'h00;
      last_code   <= 8'h00;
      hold_cnt    <= '0;
      drop_pend   <= 1'b0;
      tone_switch <= 1'b0;
      autoplay    <= 1'b0;
      channel_en  <= '0;
      mute        <= 1'b0;
      volume      <= VOL_INIT;
      cmd_ack     <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      if (strobe_take) cmd_reg <= code;
      // Dropped strobes are reported one edge later so they line up with
      // the timing of EXEC results
      drop_pend <= strobe_drop;

      case (state)
        EXEC: begin
          last_code <= cmd_reg;
          hold_cnt  <= HOLD_LOAD;
        end
        HOLD: begin
          // A suppressed repeat restarts the window so a held key stays muted
          if (strobe_drop)            hold_cnt <= HOLD_LOAD;
          else if (hold_cnt != '0)    hold_cnt <= hold_cnt - CNT_W'(1);
        end
        default: hold_cnt <= '0;
      endcase

      tone_switch <= tone_nxt;
      autoplay    <= auto_nxt;
      channel_en  <= ch_nxt;
      mute        <= mute_nxt;
      volume      <= vol_nxt;
      cmd_ack     <= ack_nxt;
      cmd_drop    <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_ir_control_bank.sv
// tb/tb_ir_control_bank.sv - directed self-checking bench for ir_control_bank
module tb_ir_control_bank;

  logic       clk;
  logic       iRST;
  logic [7:0] code;
  logic       code_valid;
  logic       tone_switch, autoplay, mute, cmd_ack, cmd_drop;
  logic [3:0] channel_en;
  logic [3:0] volume;

  int passed = 0;
  int total  = 0;

  ir_control_bank #(
    .NUM_CH(4), .VOL_W(4), .VOL_RESET(8), .HOLDOFF_CYCLES(100),
    .CH_OFF_BASE(8'h10), .CH_ON_BASE(8'h20), .CH_TOG_BASE(8'h30)
  ) dut (
    .clk(clk), .iRST(iRST), .code(code), .code_valid(code_valid),
    .tone_switch(tone_switch), .autoplay(autoplay), .channel_en(channel_en),
    .mute(mute), .volume(volume), .cmd_ack(cmd_ack), .cmd_drop(cmd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe one code; returns at the negedge after the result edge, where
  // state outputs and the ack/drop pulse are visible. A junk code level is
  // left on the bus afterwards to show it has no effect without a strobe.
  task automatic send(input logic [7:0] c);
    @(negedge clk); code = c; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0; code = 8'hA5;
    @(negedge clk);
  endtask

  initial begin
    iRST = 1'b1; code = 8'h00; code_valid = 1'b0;
    repeat (3) @(negedge clk);
    iRST = 1'b0;
    @(negedge clk);

    // 1: reset values and basic latency
    check("rst_tone", tone_switch, 0);
    check("rst_auto", autoplay, 0);
    check("rst_ch", channel_en, 0);
    check("rst_mute", mute, 0);
    check("rst_vol", volume, 8);
    check("rst_ack", cmd_ack, 0);
    check("rst_drop", cmd_drop, 0);
    @(negedge clk); code = 8'h02; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0;
    check("t1_tone_early", tone_switch, 0);
    @(negedge clk);
    check("t1_tone", tone_switch, 1);
    check("t1_ack", cmd_ack, 1);
    @(negedge clk);
    check("t1_ack_once", cmd_ack, 0);
    repeat (200) @(negedge clk);

    // 2: holdoff suppresses a repeated toggle
    send(8'h30);
    check("t2_ch_on", channel_en, 4'b0001);
    check("t2_ack1", cmd_ack, 1);
    repeat (47) @(negedge clk);
    send(8'h30);
    check("t2_drop", cmd_drop, 1);
    check("t2_noack", cmd_ack, 0);
    check("t2_ch_kept", channel_en, 4'b0001);
    repeat (200) @(negedge clk);
    send(8'h30);
    check("t2_ch_off", channel_en, 4'b0000);
    check("t2_ack2", cmd_ack, 1);

    // 3: volume auto-repeat and saturation (8 -> 14 -> 15 x3 -> 14)
    for (int i = 0; i < 6; i++) begin
      send(8'h06);
      repeat (7) @(negedge clk);
    end
    check("t3_vol14", volume, 14);
    for (int i = 0; i < 3; i++) begin
      send(8'h06);
      check("t3_vol15", volume, 15);
      check("t3_ack_sat", cmd_ack, 1);
      repeat (7) @(negedge clk);
    end
    send(8'h07);
    check("t3_vol_dn", volume, 14);

    // 4: mute interplay and different keys inside holdoff
    send(8'h05);
    check("t4_mute_on", mute, 1);
    send(8'h07);
    check("t4_mute_clr", mute, 0);
    check("t4_vol13", volume, 13);
    send(8'h05);
    check("t4_mute_tog", mute, 1);
    check("t4_ack_mute", cmd_ack, 1);
    send(8'h21);
    check("t4_ch1", channel_en, 4'b0010);
    check("t4_ack_ch", cmd_ack, 1);
    check("t4_mute_kept", mute, 1);
    repeat (200) @(negedge clk);

    // 5: unknown / out-of-range codes and back-to-back strobes
    send(8'h14);
    check("t5_drop14", cmd_drop, 1);
    check("t5_noack14", cmd_ack, 0);
    check("t5_ch14", channel_en, 4'b0010);
    send(8'h99);
    check("t5_drop99", cmd_drop, 1);
    check("t5_ch99", channel_en, 4'b0010);
    @(negedge clk); code = 8'h01; code_valid = 1'b1;
    @(negedge clk); code = 8'h04; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0;
    check("t5_b2b_tone", tone_switch, 0);
    check("t5_b2b_ack", cmd_ack, 1);
    check("t5_b2b_nodrop", cmd_drop, 0);
    @(negedge clk);
    check("t5_b2b_drop", cmd_drop, 1);
    check("t5_b2b_auto", autoplay, 0);
    repeat (200) @(negedge clk);

    // 6: reset while EXEC discards the pending command
    @(negedge clk); code = 8'h04; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0; iRST = 1'b1;
    @(negedge clk); iRST = 1'b0;
    check("t6_auto_rst", autoplay, 0);
    check("t6_state_idle", dut.state, 0);
    check("t6_vol_rst", volume, 8);
    repeat (3) @(negedge clk);
    check("t6_auto_stays", autoplay, 0);
    send(8'h04);
    check("t6_auto_set", autoplay, 1);
    check("t6_ack", cmd_ack, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
